cordic_scheduler: RTL and testbench

Issue scheduler for the 16-stage pipelined `cordic` cosine unit. It arbitrates between two requesters using round-robin. It tracks which requester owns each in-flight operation with a tag shift register that mirrors the pipeline, and it routes each result back with valid/ready handshakes. When a result cannot be delivered, it stalls the whole pipeline through the `cordic` clock enable. It also sequences the pipeline's synchronous clear on reset and on flush.

---
 rtl/cordic_scheduler_pkg.sv | 14 +
 rtl/cordic_scheduler_if.sv | 25 ++
 rtl/cordic_scheduler_arbiter.sv | 22 ++
 rtl/cordic_scheduler.sv | 100 ++++++++++
 tb/tb_cordic_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_scheduler_pkg.sv
// Shared types and constants for the cordic issue scheduler.
package cordic_sched_pkg;

  localparam int CORDIC_LATENCY = 16;
  localparam int NUM_REQ        = 2;
  localparam int TAG_W          = 1;

  // One slot of the tag shift register that shadows the cordic stages.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } sched_entry_t;

endpackage

// File: rtl/cordic_scheduler_if.sv
// Requester-side handshake bundle: operand issue and result return.
interface cordic_scheduler_if #(
  parameter int DATA_W = 32
);

  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][DATA_W-1:0] req_data;
  logic [1:0]             resp_valid;
  logic [1:0]             resp_ready;
  logic [DATA_W-1:0]      resp_data;

  // Requesters drive operands and accept results.
  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  // The scheduler accepts operands and presents results.
  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/cordic_scheduler_arbiter.sv
// Two-way round-robin arbiter: requester ptr wins ties, a lone request always wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       gidx
);

  // Priority goes to ptr first, then to the other requester.
  always_comb begin
    grant = 2'b00;
    gidx  = 1'b0;
    if (req[ptr]) begin
      grant[ptr] = 1'b1;
      gidx       = ptr;
    end else if (req[~ptr]) begin
      grant[~ptr] = 1'b1;
      gidx        = ~ptr;
    end
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Issue scheduler for the pipelined cordic cosine unit: round-robin issue,
// ownership tracking of in-flight operations, result routing with stall,
// and sequencing of the pipeline's synchronous clear.
module cordic_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int LATENCY = 16,
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
) (
  input  logic                clock,
  input  logic                aclr_n,
  input  logic                flush,
  cordic_scheduler_if.slave   bus,
  output logic [31:0]         cordic_dataa,
  output logic                cordic_clk_en,
  output logic                cordic_aclr,
  input  logic [31:0]         cordic_result,
  output logic                busy,
  output logic [CNT_W-1:0]    done_count
);

  logic               rst_pend;
  logic               ptr;
  sched_entry_t       tag_pipe [LATENCY];
  sched_entry_t       top_e;
  logic               aclr_int;
  logic               stall;
  logic               clk_en;
  logic [1:0]         arb_req;
  logic [NUM_REQ-1:0] grant;
  logic               gidx;
  logic [1:0]         hs;

  assign top_e    = tag_pipe[LATENCY-1];
  assign aclr_int = rst_pend | flush;

  // A result whose owner is not ready freezes the whole pipeline.
  assign stall  = top_e.valid & ~bus.resp_ready[top_e.tag];
  assign clk_en = ~stall & ~aclr_int;

  // No request is considered while the clear is still pending, so the
  // operand bus stays at zero through reset.
  assign arb_req = bus.req_valid & {2{~rst_pend}};

  rr_arbiter2 u_arb (
    .req   (arb_req),
    .ptr   (ptr),
    .grant (grant),
    .gidx  (gidx)
  );

  assign bus.req_ready = grant & {2{clk_en}};
  assign cordic_dataa  = (|grant) ? bus.req_data[gidx] : 32'd0;

  assign bus.resp_valid[0] = top_e.valid & (top_e.tag == 1'b0) & ~aclr_int;
  assign bus.resp_valid[1] = top_e.valid & (top_e.tag == 1'b1) & ~aclr_int;
  assign bus.resp_data     = cordic_result;
  assign hs                = bus.resp_valid & bus.resp_ready;

  assign cordic_clk_en = clk_en;
  assign cordic_aclr   = aclr_int;

  // Hold the cordic clear for one edge beyond reset release.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) rst_pend <= 1'b1;
    else         rst_pend <= 1'b0;
  end

  // Round-robin pointer moves to the other requester after each accepted issue.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n)                ptr <= 1'b0;
    else if (clk_en && |grant)  ptr <= ~gidx;
  end

  // Stage boundary: issue slot enters entry 0, top entry retires on the same edge.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int i = 0; i < LATENCY; i++) tag_pipe[i] <= '0;
    end else if (aclr_int) begin
      for (int i = 0; i < LATENCY; i++) tag_pipe[i] <= '0;
    end else if (clk_en) begin
      tag_pipe[0] <= {|grant, gidx};
      for (int i = 1; i < LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  // Count delivered results; wraps naturally at the counter width.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n)  done_count <= '0;
    else if (|hs) done_count <= done_count + CNT_W'(1);
  end

  // Anything in flight keeps busy high.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LATENCY; i++) busy = busy | tag_pipe[i].valid;
  end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Bench for cordic_scheduler with a 16-stage stand-in for the cordic unit.
module tb_cordic_scheduler;

  logic        clock = 1'b0;
  logic        aclr_n;
  logic        flush;
  logic [31:0] cordic_dataa;
  logic        cordic_clk_en;
  logic        cordic_aclr;
  logic [31:0] cordic_result;
  logic        busy;
  logic [15:0] done_count;

  always #5 clock = ~clock;

  cordic_scheduler_if bus ();

  cordic_scheduler #(.LATENCY(16), .NUM_REQ(2), .CNT_W(16)) dut (
    .clock         (clock),
    .aclr_n        (aclr_n),
    .flush         (flush),
    .bus           (bus.slave),
    .cordic_dataa  (cordic_dataa),
    .cordic_clk_en (cordic_clk_en),
    .cordic_aclr   (cordic_aclr),
    .cordic_result (cordic_result),
    .busy          (busy),
    .done_count    (done_count)
  );

  // Stand-in result function: the known cos(0.5) point, otherwise a fixed XOR.
  function automatic logic [31:0] tb_cos(input logic [31:0] a);
    return (a == 32'h3F000000) ? 32'h3F60A8B6 : (a ^ 32'h5A5A5A5A);
  endfunction

  // Stand-in cordic pipeline: 16 stages, clock enable, synchronous clear.
  logic [31:0] stg [16] = '{default: '0};
  always @(posedge clock) begin
    if (cordic_aclr) begin
      for (int i = 0; i < 16; i++) stg[i] <= '0;
    end else if (cordic_clk_en) begin
      stg[0] <= tb_cos(cordic_dataa);
      for (int i = 1; i < 16; i++) stg[i] <= stg[i-1];
    end
  end
  assign cordic_result = stg[15];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard of accepted operands, in issue order.
  typedef struct {
    logic        tag;
    logic [31:0] data;
  } exp_t;
  exp_t        sbq[$];
  logic        sb_en     = 1'b1;
  logic        hs_seen   = 1'b0;
  logic [15:0] exp_count = '0;

  always @(negedge clock) begin
    hs_seen <= aclr_n & |(bus.resp_valid & bus.resp_ready);
    if (aclr_n) begin
      for (int i = 0; i < 2; i++) begin
        if (bus.resp_valid[i] && bus.resp_ready[i]) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp: got resp on requester %0d expected none", i);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            if (sb_en) begin
              check("resp_tag", 32'(i), {31'd0, e.tag});
              check("resp_data", bus.resp_data, e.data);
            end
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i])
          sbq.push_back('{tag: i[0], data: tb_cos(bus.req_data[i])});
      end
    end
  end

  always @(posedge clock) begin
    if (!aclr_n)      exp_count <= '0;
    else if (hs_seen) exp_count <= exp_count + 16'd1;
  end

  typedef struct {
    logic [1:0] rv;
    logic [1:0] exp_rdy;
  } arb_vec_t;
  arb_vec_t vecs [10];

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 60 && !idle; k++) begin
      @(negedge clock);
      if (!busy) idle = 1'b1;
    end
    check("idle_timeout", {31'd0, idle}, 32'd1);
  endtask

  task automatic single_op(input logic [31:0] d, input logic [31:0] exp_res);
    int cnt;
    bit seen;
    @(posedge clock); #1;
    bus.req_valid   = 2'b01;
    bus.req_data[0] = d;
    @(negedge clock);
    check("so_ready", {30'd0, bus.req_ready}, 32'h1);
    @(posedge clock); #1;
    bus.req_valid = 2'b00;
    cnt  = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clock);
      cnt++;
      if (bus.resp_valid[0]) seen = 1'b1;
    end
    check("so_latency", 32'(cnt), 32'd16);
    check("so_data", bus.resp_data, exp_res);
    @(negedge clock);
    check("so_pulse", {30'd0, bus.resp_valid}, 32'h0);
  endtask

  initial begin
    int  rv_cnt;
    bit  found;
    logic [31:0] exp_d;

    // Pointer is 1 when the table starts (the preceding op went to requester 0).
    vecs[0] = '{2'b11, 2'b10};
    vecs[1] = '{2'b11, 2'b01};
    vecs[2] = '{2'b01, 2'b01};
    vecs[3] = '{2'b01, 2'b01};
    vecs[4] = '{2'b10, 2'b10};
    vecs[5] = '{2'b00, 2'b00};
    vecs[6] = '{2'b11, 2'b01};
    vecs[7] = '{2'b10, 2'b10};
    vecs[8] = '{2'b10, 2'b10};
    vecs[9] = '{2'b10, 2'b10};

    aclr_n          = 1'b0;
    flush           = 1'b0;
    bus.req_valid   = 2'b11;
    bus.req_data[0] = 32'h11111111;
    bus.req_data[1] = 32'h22222222;
    bus.resp_ready  = 2'b11;

    // Reset held for three cycles.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_req_ready", {30'd0, bus.req_ready}, 32'h0);
    check("rst_resp_valid", {30'd0, bus.resp_valid}, 32'h0);
    check("rst_clk_en", {31'd0, cordic_clk_en}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_aclr", {31'd0, cordic_aclr}, 32'h1);
    check("rst_done_count", {16'd0, done_count}, 32'h0);
    check("rst_dataa", cordic_dataa, 32'h0);

    @(posedge clock); #1;
    aclr_n = 1'b1;
    @(negedge clock);
    check("rel_aclr_held", {31'd0, cordic_aclr}, 32'h1);
    check("rel_ready_held", {30'd0, bus.req_ready}, 32'h0);
    @(negedge clock);
    check("rel_aclr_drop", {31'd0, cordic_aclr}, 32'h0);
    check("rel_first_grant", {30'd0, bus.req_ready}, 32'h1);
    check("rel_first_dataa", cordic_dataa, 32'h11111111);
    @(posedge clock); #1;
    bus.req_valid = 2'b00;
    wait_idle();
    check("first_done_count", {16'd0, done_count}, 32'd1);

    // Single operation with the cos(0.5) operand.
    single_op(32'h3F000000, 32'h3F60A8B6);
    check("single_done_count", {16'd0, done_count}, 32'd2);

    // Arbitration table.
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      bus.req_valid   = vecs[k].rv;
      bus.req_data[0] = 32'h40000000 + 32'(k);
      bus.req_data[1] = 32'h41000000 + 32'(k);
      @(negedge clock);
      check($sformatf("arb_ready_%0d", k), {30'd0, bus.req_ready}, {30'd0, vecs[k].exp_rdy});
      exp_d = vecs[k].exp_rdy[1] ? (32'h41000000 + 32'(k)) :
              vecs[k].exp_rdy[0] ? (32'h40000000 + 32'(k)) : 32'h0;
      check($sformatf("arb_dataa_%0d", k), cordic_dataa, exp_d);
    end
    @(posedge clock); #1;
    bus.req_valid = 2'b00;
    wait_idle();
    check("arb_done_count", {16'd0, done_count}, 32'd11);

    // Contention: both stream for eight cycles.
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      bus.req_valid   = 2'b11;
      bus.req_data[0] = 32'h50000000 + 32'(i);
      bus.req_data[1] = 32'h51000000 + 32'(i);
      @(negedge clock);
      check($sformatf("cont_grant_%0d", i), {30'd0, bus.req_ready}, (i % 2 == 1) ? 32'h2 : 32'h1);
    end
    @(posedge clock); #1;
    bus.req_valid = 2'b00;
    rv_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (|bus.resp_valid) rv_cnt++;
    end
    check("cont_resp_cycles", 32'(rv_cnt), 32'd8);
    check("cont_done_count", {16'd0, done_count}, 32'd19);

    // Backpressure on requester 1.
    @(posedge clock); #1;
    bus.resp_ready  = 2'b01;
    bus.req_valid   = 2'b10;
    bus.req_data[1] = 32'h12345678;
    @(negedge clock);
    check("bp_issue", {30'd0, bus.req_ready}, 32'h2);
    @(posedge clock); #1;
    bus.req_valid = 2'b00;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clock);
      if (bus.resp_valid[1]) found = 1'b1;
    end
    check("bp_arrive", {31'd0, found}, 32'h1);
    @(posedge clock); #1;
    bus.req_valid   = 2'b11;
    bus.req_data[0] = 32'hAAAA0000;
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      check("bp_clk_en", {31'd0, cordic_clk_en}, 32'h0);
      check("bp_req_ready", {30'd0, bus.req_ready}, 32'h0);
      check("bp_resp_valid", {30'd0, bus.resp_valid}, 32'h2);
      check("bp_resp_data", bus.resp_data, 32'h486E0C22);
      check("bp_busy", {31'd0, busy}, 32'h1);
    end
    @(posedge clock); #1;
    bus.resp_ready = 2'b11;
    @(negedge clock);
    check("bp_resume_clk_en", {31'd0, cordic_clk_en}, 32'h1);
    check("bp_resume_ready", {30'd0, bus.req_ready}, 32'h1);
    check("bp_resume_valid", {30'd0, bus.resp_valid}, 32'h2);
    @(posedge clock); #1;
    bus.req_valid = 2'b00;
    @(negedge clock);
    check("bp_no_dup", {30'd0, bus.resp_valid}, 32'h0);
    check("bp_done_count", {16'd0, done_count}, 32'd20);
    wait_idle();
    check("bp_drain_count", {16'd0, done_count}, 32'd21);

    // Flush with five operations in flight.
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      bus.req_valid   = 2'b01;
      bus.req_data[0] = 32'h60000000 + 32'(i);
    end
    @(posedge clock); #1;
    bus.req_valid = 2'b00;
    @(negedge clock);
    check("fl_busy_before", {31'd0, busy}, 32'h1);
    @(posedge clock); #1;
    flush         = 1'b1;
    bus.req_valid = 2'b11;
    @(negedge clock);
    check("fl_req_ready", {30'd0, bus.req_ready}, 32'h0);
    check("fl_resp_valid", {30'd0, bus.resp_valid}, 32'h0);
    check("fl_clk_en", {31'd0, cordic_clk_en}, 32'h0);
    check("fl_aclr", {31'd0, cordic_aclr}, 32'h1);
    @(posedge clock); #1;
    flush         = 1'b0;
    bus.req_valid = 2'b00;
    sbq.delete();
    @(negedge clock);
    check("fl_busy_after", {31'd0, busy}, 32'h0);
    rv_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clock);
      if (|bus.resp_valid) rv_cnt++;
    end
    check("fl_no_resp", 32'(rv_cnt), 32'd0);
    check("fl_done_kept", {16'd0, done_count}, 32'd21);
    single_op(32'h3F000000, 32'h3F60A8B6);
    check("fl_after_count", {16'd0, done_count}, 32'd22);

    // Counter wrap by streaming completions.
    sb_en = 1'b0;
    @(posedge clock); #1;
    bus.req_valid  = 2'b11;
    bus.resp_ready = 2'b11;
    found = 1'b0;
    for (int k = 0; k < 70000 && !found; k++) begin
      @(negedge clock);
      if (exp_count == 16'hFFFF) found = 1'b1;
    end
    check("wrap_reached", {31'd0, found}, 32'h1);
    check("wrap_ffff", {16'd0, done_count}, 32'h0000FFFF);
    @(negedge clock);
    check("wrap_zero", {16'd0, done_count}, 32'h0);

    // Asynchronous reset mid-stream.
    @(posedge clock); #1;
    bus.req_valid = 2'b00;
    #2;
    aclr_n = 1'b0;
    #1;
    check("ar_busy", {31'd0, busy}, 32'h0);
    check("ar_done_count", {16'd0, done_count}, 32'h0);
    check("ar_aclr", {31'd0, cordic_aclr}, 32'h1);
    check("ar_resp_valid", {30'd0, bus.resp_valid}, 32'h0);
    check("ar_clk_en", {31'd0, cordic_clk_en}, 32'h0);
    sbq.delete();
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
